// File: rtl/cga_pkg.sv
// Shared definitions for the CGA core: arbiter state encoding and address widths.
package cga_pkg;

  localparam int VADDR_W = 14;
  localparam int RADDR_W = 19;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_VID,
    ARB_CPU_RD,
    ARB_CPU_WR
  } arb_state_t;

endpackage

// File: rtl/cga_vram_access_timer.sv
// Counts the cycles of one SRAM access and flags its first cycle, last cycle
// and the write-enable window (every cycle after the address-setup cycle).
module cga_vram_access_timer #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  output logic first,
  output logic last,
  output logic we_win
);

  localparam int CW = $clog2(ACCESS_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(ACCESS_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !busy || cnt == LAST_CNT) cnt <= '0;
    else                                 cnt <= cnt + 1'b1;
  end

  assign first  = busy && (cnt == '0);
  assign last   = busy && (cnt == LAST_CNT);
  assign we_win = busy && (cnt != '0);

endmodule

// File: rtl/cga_vram_arbiter.sv
// Shares the single VRAM SRAM port between sequencer video fetches (priority)
// and ISA CPU cycles, which are stretched through cpu_wait until serviced.
module cga_vram_arbiter
  import cga_pkg::*;
#(
  parameter int         ACCESS_CYCLES = 2,
  parameter logic [4:0] BANK          = 5'd0,
  parameter int         CPU_FORCE     = 0
) (
  input  logic               clk,
  input  logic               busreset,
  input  logic               vid_req,
  input  logic [VADDR_W-1:0] vid_addr,
  output logic [7:0]         vid_data,
  output logic               vid_valid,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VADDR_W-1:0] cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_ack,
  output logic               cpu_wait,
  output logic [RADDR_W-1:0] ram_a,
  input  logic [7:0]         ram_d_in,
  output logic [7:0]         ram_d_out,
  output logic               ram_d_oe,
  output logic               ram_we_l
);

  localparam int SW = (CPU_FORCE > 0) ? $clog2(CPU_FORCE + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(CPU_FORCE);

  arb_state_t state, state_nxt;

  logic               busy, first, last, we_win;
  logic               pend_valid;
  logic [VADDR_W-1:0] pend_addr;
  logic               armed;
  logic [SW-1:0]      streak;
  logic               wr_tail;
  logic [7:0]         wdata;
  logic               vid_overflow;
  logic               vid_pending, cpu_pending, force_cpu;
  logic               grant_vid, grant_cpu;
  logic               cpu_access;

  assign busy        = (state != ARB_IDLE);
  assign cpu_access  = (state == ARB_CPU_RD) || (state == ARB_CPU_WR);
  assign vid_pending = pend_valid || vid_req;
  assign cpu_pending = cpu_req && armed;
  assign force_cpu   = (CPU_FORCE != 0) && (streak == STREAK_MAX) && cpu_pending;
  assign grant_vid   = (state == ARB_IDLE) && vid_pending && !force_cpu;
  assign grant_cpu   = (state == ARB_IDLE) && cpu_pending && (force_cpu || !vid_pending);

  cga_vram_access_timer #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (busreset),
    .busy  (busy),
    .first (first),
    .last  (last),
    .we_win(we_win)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE: begin
        if (grant_vid)      state_nxt = ARB_VID;
        else if (grant_cpu) state_nxt = cpu_we ? ARB_CPU_WR : ARB_CPU_RD;
      end
      ARB_VID, ARB_CPU_RD, ARB_CPU_WR: begin
        if (last) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (busreset) state <= ARB_IDLE;
    else          state <= state_nxt;
  end

  // Grant stage: latch the address (and write data) that the access will use
  always_ff @(posedge clk) begin
    if (busreset)       ram_a <= '0;
    else if (grant_vid) ram_a <= {BANK, pend_valid ? pend_addr : vid_addr};
    else if (grant_cpu) ram_a <= {BANK, cpu_addr};
  end

  always_ff @(posedge clk) begin
    if (grant_cpu) wdata <= cpu_wdata;
  end

  // A request granted straight from IDLE is consumed; one behind a pending entry queues
  always_ff @(posedge clk) begin
    if (busreset)       pend_valid <= 1'b0;
    else if (vid_req)   pend_valid <= !(grant_vid && !pend_valid);
    else if (grant_vid) pend_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (vid_req) pend_addr <= vid_addr;
  end

  // Sticky marker of a lost fetch request; only observed in simulation
  always_ff @(posedge clk) begin
    if (busreset)                                  vid_overflow <= 1'b0;
    else if (vid_req && pend_valid && !grant_vid) vid_overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (busreset)                 armed <= 1'b0;
    else if (cpu_access && last) armed <= 1'b0;
    else if (!cpu_req)           armed <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (busreset || !cpu_req || grant_cpu)
      streak <= '0;
    else if (grant_vid && cpu_pending && streak != STREAK_MAX)
      streak <= streak + 1'b1;
  end

  // Completion stage: capture read data and strobe the requester
  always_ff @(posedge clk) begin
    if (busreset) begin
      vid_valid <= 1'b0;
      cpu_ack   <= 1'b0;
      wr_tail   <= 1'b0;
      vid_data  <= '0;
      cpu_rdata <= '0;
    end else begin
      vid_valid <= (state == ARB_VID) && last;
      cpu_ack   <= cpu_access && last;
      wr_tail   <= (state == ARB_CPU_WR) && last;
      if ((state == ARB_VID) && last)    vid_data  <= ram_d_in;
      if ((state == ARB_CPU_RD) && last) cpu_rdata <= ram_d_in;
    end
  end

  assign cpu_wait  = cpu_req && armed;
  assign ram_d_out = wdata;
  assign ram_we_l  = busreset || !((state == ARB_CPU_WR) && we_win);
  assign ram_d_oe  = !busreset && ((state == ARB_CPU_WR) || wr_tail);

  ap_addr_stable: assert property (@(posedge clk) disable iff (busreset)
    first |=> $stable(ram_a));

endmodule
